// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: datapath widths, control-bundle bit positions, PC register index.
package cpu_pipe_pkg;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 10;

    localparam int CTRL_RFLD      = 0;
    localparam int CTRL_LOAD      = 1;
    localparam int CTRL_MEMW      = 2;
    localparam int CTRL_ALUOP_LSB = 3;
    localparam int CTRL_S         = 7;

    localparam logic [3:0] PC_REG = 4'd15;
endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding select for one operand: EX > MEM > WB > register file; R15 never forwarded.
module fwd_mux
    import cpu_pipe_pkg::*;
#(
    parameter int DW = cpu_pipe_pkg::DW,
    parameter int RW = cpu_pipe_pkg::RW
) (
    input  logic [RW-1:0] sel,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_fwd,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_rfld,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_rfld,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] pw,
    output logic [DW-1:0] data
);
    always_comb begin
        data = rf_data;
        if (sel != RW'(PC_REG)) begin
            if (ex_fwd && ex_rd == sel)           data = ex_result;
            else if (mem_rfld && mem_rd == sel)   data = mem_result;
            else if (wb_rfld && wb_rd == sel)     data = pw;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: operand forwarding, load-use stall, ID/EX pipeline register.
// Optional perf counters (STALL_CNT/FLUSH_CNT) enabled by ID_EX_PERF_CNT_EN.
module id_ex_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DW = cpu_pipe_pkg::DW,
    parameter int RW = cpu_pipe_pkg::RW,
    parameter int CW = cpu_pipe_pkg::CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] PA,
    input  logic [DW-1:0] PB,
    input  logic [DW-1:0] PD,
    input  logic [RW-1:0] SA,
    input  logic [RW-1:0] SB,
    input  logic [RW-1:0] SD,
    input  logic          USE_A,
    input  logic          USE_B,
    input  logic          USE_D,
    input  logic [RW-1:0] ID_RD,
    input  logic [CW-1:0] ID_CTRL,
    input  logic [DW-1:0] ID_IMM,
    input  logic          ID_VALID,
    input  logic [DW-1:0] EX_RESULT,
    input  logic [RW-1:0] MEM_RD,
    input  logic          MEM_RFLD,
    input  logic [DW-1:0] MEM_RESULT,
    input  logic [RW-1:0] WB_RD,
    input  logic          WB_RFLD,
    input  logic [DW-1:0] PW,
    input  logic          FLUSH,
    output logic [DW-1:0] EX_A,
    output logic [DW-1:0] EX_B,
    output logic [DW-1:0] EX_D,
    output logic [DW-1:0] EX_IMM,
    output logic [CW-1:0] EX_CTRL,
    output logic [RW-1:0] EX_RD,
    output logic          EX_VALID,
    output logic          HZPCld,
    output logic          IFID_Ld
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]   STALL_CNT,
    output logic [15:0]   FLUSH_CNT
`endif
);
    logic [2:0][RW-1:0] src;
    logic [2:0][DW-1:0] rf_val;
    logic [2:0][DW-1:0] fwd_val;
    logic [2:0]         use_v;

    logic [2:0][DW-1:0] opnd_q, opnd_d;
    logic [DW-1:0]      imm_q, imm_d;
    logic [CW-1:0]      ctrl_q, ctrl_d;
    logic [RW-1:0]      rd_q, rd_d;
    logic               valid_q, valid_d;

    logic ex_fwd;
    logic stall;

    assign src    = {SD, SB, SA};
    assign rf_val = {PD, PB, PA};
    assign use_v  = {USE_D, USE_B, USE_A};

    // A load in EX has no result yet; its data arrives from MEM one cycle later.
    assign ex_fwd = valid_q & ctrl_q[CTRL_RFLD] & ~ctrl_q[CTRL_LOAD];

    for (genvar i = 0; i < 3; i++) begin : g_fwd
        fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
            .sel        (src[i]),
            .rf_data    (rf_val[i]),
            .ex_fwd     (ex_fwd),
            .ex_rd      (rd_q),
            .ex_result  (EX_RESULT),
            .mem_rfld   (MEM_RFLD),
            .mem_rd     (MEM_RD),
            .mem_result (MEM_RESULT),
            .wb_rfld    (WB_RFLD),
            .wb_rd      (WB_RD),
            .pw         (PW),
            .data       (fwd_val[i])
        );
    end

    always_comb begin
        stall = 1'b0;
        if (ID_VALID && valid_q && ctrl_q[CTRL_LOAD] && ctrl_q[CTRL_RFLD] &&
            rd_q != RW'(PC_REG)) begin
            for (int i = 0; i < 3; i++)
                if (use_v[i] && src[i] == rd_q) stall = 1'b1;
        end
    end

    assign HZPCld  = RST & (~stall | FLUSH);
    assign IFID_Ld = HZPCld;

    always_comb begin
        opnd_d  = '0;
        imm_d   = '0;
        ctrl_d  = '0;
        rd_d    = '0;
        valid_d = 1'b0;
        if (!FLUSH && !stall) begin
            opnd_d  = fwd_val;
            imm_d   = ID_IMM;
            ctrl_d  = ID_VALID ? ID_CTRL : '0;
            rd_d    = ID_RD;
            valid_d = ID_VALID;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            opnd_q  <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            opnd_q  <= opnd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign EX_A     = opnd_q[0];
    assign EX_B     = opnd_q[1];
    assign EX_D     = opnd_q[2];
    assign EX_IMM   = imm_q;
    assign EX_CTRL  = ctrl_q;
    assign EX_RD    = rd_q;
    assign EX_VALID = valid_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // A flush hides a coincident stall, so only the flush is counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (FLUSH && flush_cnt_q != 16'hFFFF)                flush_cnt_d = flush_cnt_q + 16'd1;
        if (!FLUSH && stall && stall_cnt_q != 16'hFFFF)      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, R15, load-use, flush, unused ports.
module tb_id_ex_stage;
    logic        CLK, RST;
    logic [31:0] PA, PB, PD, ID_IMM, EX_RESULT, MEM_RESULT, PW;
    logic [3:0]  SA, SB, SD, ID_RD, MEM_RD, WB_RD;
    logic        USE_A, USE_B, USE_D, ID_VALID, MEM_RFLD, WB_RFLD, FLUSH;
    logic [9:0]  ID_CTRL;
    logic [31:0] EX_A, EX_B, EX_D, EX_IMM;
    logic [9:0]  EX_CTRL;
    logic [3:0]  EX_RD;
    logic        EX_VALID, HZPCld, IFID_Ld;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] STALL_CNT, FLUSH_CNT;
    logic [15:0] sc0, fc0;
`endif

    int nvec = 0;
    int nerr = 0;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .PA(PA), .PB(PB), .PD(PD),
        .SA(SA), .SB(SB), .SD(SD), .USE_A(USE_A), .USE_B(USE_B), .USE_D(USE_D),
        .ID_RD(ID_RD), .ID_CTRL(ID_CTRL), .ID_IMM(ID_IMM), .ID_VALID(ID_VALID),
        .EX_RESULT(EX_RESULT), .MEM_RD(MEM_RD), .MEM_RFLD(MEM_RFLD), .MEM_RESULT(MEM_RESULT),
        .WB_RD(WB_RD), .WB_RFLD(WB_RFLD), .PW(PW), .FLUSH(FLUSH),
        .EX_A(EX_A), .EX_B(EX_B), .EX_D(EX_D), .EX_IMM(EX_IMM), .EX_CTRL(EX_CTRL),
        .EX_RD(EX_RD), .EX_VALID(EX_VALID), .HZPCld(HZPCld), .IFID_Ld(IFID_Ld)
`ifdef ID_EX_PERF_CNT_EN
        , .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        PA = 0; PB = 0; PD = 0; SA = 0; SB = 0; SD = 0;
        USE_A = 0; USE_B = 0; USE_D = 0;
        ID_RD = 0; ID_CTRL = 0; ID_IMM = 0; ID_VALID = 0;
        EX_RESULT = 0; MEM_RD = 0; MEM_RFLD = 0; MEM_RESULT = 0;
        WB_RD = 0; WB_RFLD = 0; PW = 0; FLUSH = 0;
    endtask

    // Put an instruction into EX: dest rd, ctrl bundle.
    task automatic load_ex(input logic [3:0] rd, input logic [9:0] ctrl);
        idle_inputs();
        ID_VALID = 1; ID_RD = rd; ID_CTRL = ctrl;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 0;
        ID_VALID = 1; ID_CTRL = 10'h3FF; PA = 32'hDEAD; SA = 1; USE_A = 1; ID_IMM = 32'h55; ID_RD = 7;
        tick();
        nvec++; if (EX_A !== 0 || EX_IMM !== 0 || EX_RD !== 0) begin nerr++; $display("FAIL reset_data A=%h IMM=%h RD=%h want 0", EX_A, EX_IMM, EX_RD); end
        nvec++; if (EX_VALID !== 0 || EX_CTRL !== 0) begin nerr++; $display("FAIL reset_ctrl V=%b C=%h want 0", EX_VALID, EX_CTRL); end
        nvec++; if (HZPCld !== 0 || IFID_Ld !== 0) begin nerr++; $display("FAIL reset_en HZ=%b IFID=%b want 0", HZPCld, IFID_Ld); end
        idle_inputs();
        ID_VALID = 1; PA = 5; SA = 1; USE_A = 1;
        RST = 1;
        tick();
        nvec++; if (EX_A !== 5 || EX_VALID !== 1) begin nerr++; $display("FAIL reset_release A=%h V=%b want 5 1", EX_A, EX_VALID); end
    endtask

    task automatic test_forward_priority();
        load_ex(4'd3, 10'h001);
        ID_VALID = 1; ID_RD = 5; ID_CTRL = 10'h001;
        SA = 3; USE_A = 1; PA = 32'h44;
        EX_RESULT = 32'h11; MEM_RFLD = 1; MEM_RD = 3; MEM_RESULT = 32'h22;
        WB_RFLD = 1; WB_RD = 3; PW = 32'h33;
        tick();
        nvec++; if (EX_A !== 32'h11) begin nerr++; $display("FAIL fwd_ex got %h want 11", EX_A); end
        nvec++; if (EX_RD !== 5 || EX_CTRL !== 10'h001) begin nerr++; $display("FAIL fwd_latch RD=%h C=%h want 5 001", EX_RD, EX_CTRL); end
        tick();
        nvec++; if (EX_A !== 32'h22) begin nerr++; $display("FAIL fwd_mem got %h want 22", EX_A); end
        MEM_RFLD = 0;
        tick();
        nvec++; if (EX_A !== 32'h33) begin nerr++; $display("FAIL fwd_wb got %h want 33", EX_A); end
        WB_RFLD = 0;
        tick();
        nvec++; if (EX_A !== 32'h44) begin nerr++; $display("FAIL fwd_rf got %h want 44", EX_A); end
    endtask

    task automatic test_r15();
        load_ex(4'd15, 10'h001);
        ID_VALID = 1; ID_RD = 0; ID_CTRL = 10'h001;
        SB = 15; USE_B = 1; PB = 32'h100; EX_RESULT = 32'h999;
        MEM_RFLD = 1; MEM_RD = 15; MEM_RESULT = 32'h888;
        WB_RFLD = 1; WB_RD = 15; PW = 32'h777;
        tick();
        nvec++; if (EX_B !== 32'h100) begin nerr++; $display("FAIL r15 got %h want 100", EX_B); end
    endtask

    task automatic test_load_use();
`ifdef ID_EX_PERF_CNT_EN
        sc0 = STALL_CNT; fc0 = FLUSH_CNT;
`endif
        load_ex(4'd4, 10'h003);
        ID_VALID = 1; ID_RD = 6; ID_CTRL = 10'h001; ID_IMM = 32'h77;
        SD = 4; USE_D = 1; PD = 32'h1;
        #1;
        nvec++; if (HZPCld !== 0 || IFID_Ld !== 0) begin nerr++; $display("FAIL lu_stall HZ=%b IFID=%b want 0 0", HZPCld, IFID_Ld); end
        tick();
        nvec++; if (EX_VALID !== 0 || EX_CTRL !== 0) begin nerr++; $display("FAIL lu_bubble V=%b C=%h want 0 0", EX_VALID, EX_CTRL); end
        nvec++; if (HZPCld !== 1 || IFID_Ld !== 1) begin nerr++; $display("FAIL lu_one_cycle HZ=%b IFID=%b want 1 1", HZPCld, IFID_Ld); end
        MEM_RFLD = 1; MEM_RD = 4; MEM_RESULT = 32'hABCD;
        tick();
        nvec++; if (EX_D !== 32'hABCD || EX_VALID !== 1 || EX_IMM !== 32'h77) begin
            nerr++; $display("FAIL lu_mem_fwd D=%h V=%b IMM=%h want abcd 1 77", EX_D, EX_VALID, EX_IMM); end
`ifdef ID_EX_PERF_CNT_EN
        nvec++; if (STALL_CNT !== sc0 + 16'd1 || FLUSH_CNT !== fc0) begin
            nerr++; $display("FAIL lu_cnt S=%0d F=%0d want %0d %0d", STALL_CNT, FLUSH_CNT, sc0 + 16'd1, fc0); end
`endif
    endtask

    task automatic test_flush_stall();
        load_ex(4'd4, 10'h003);
`ifdef ID_EX_PERF_CNT_EN
        sc0 = STALL_CNT; fc0 = FLUSH_CNT;
`endif
        ID_VALID = 1; ID_RD = 6; ID_CTRL = 10'h001; SD = 4; USE_D = 1; PD = 32'h9; FLUSH = 1;
        #1;
        nvec++; if (HZPCld !== 1 || IFID_Ld !== 1) begin nerr++; $display("FAIL flush_en HZ=%b IFID=%b want 1 1", HZPCld, IFID_Ld); end
        tick();
        nvec++; if (EX_VALID !== 0 || EX_CTRL !== 0 || EX_D !== 0) begin
            nerr++; $display("FAIL flush_bubble V=%b C=%h D=%h want 0 0 0", EX_VALID, EX_CTRL, EX_D); end
`ifdef ID_EX_PERF_CNT_EN
        nvec++; if (FLUSH_CNT !== fc0 + 16'd1 || STALL_CNT !== sc0) begin
            nerr++; $display("FAIL flush_cnt S=%0d F=%0d want %0d %0d", STALL_CNT, FLUSH_CNT, sc0, fc0 + 16'd1); end
`endif
        FLUSH = 0;
    endtask

    task automatic test_unused_port();
        load_ex(4'd2, 10'h003);
        ID_VALID = 1; ID_RD = 1; ID_CTRL = 10'h001; SA = 2; USE_A = 0;
        #1;
        nvec++; if (HZPCld !== 1) begin nerr++; $display("FAIL unused_nostall HZ=%b want 1", HZPCld); end
        tick();
        nvec++; if (EX_VALID !== 1) begin nerr++; $display("FAIL unused_adv V=%b want 1", EX_VALID); end
    endtask

    task automatic test_invalid_id();
        idle_inputs();
        ID_VALID = 0; ID_CTRL = 10'h3FF; ID_RD = 9;
        tick();
        nvec++; if (EX_VALID !== 0 || EX_CTRL !== 0) begin nerr++; $display("FAIL invalid_ctrl V=%b C=%h want 0 0", EX_VALID, EX_CTRL); end
    endtask

    task automatic test_reset_mid_stall();
        load_ex(4'd4, 10'h003);
        ID_VALID = 1; SA = 4; USE_A = 1;
        #1;
        RST = 0;
        #1;
        nvec++; if (EX_VALID !== 0 || EX_CTRL !== 0 || EX_RD !== 0 || HZPCld !== 0) begin
            nerr++; $display("FAIL rst_mid_stall V=%b C=%h RD=%h HZ=%b want 0 0 0 0", EX_VALID, EX_CTRL, EX_RD, HZPCld); end
        RST = 1;
        #1;
        nvec++; if (HZPCld !== 1) begin nerr++; $display("FAIL rst_no_pending HZ=%b want 1", HZPCld); end
        tick();
    endtask

    initial begin
        RST = 0;
        idle_inputs();
        test_reset();
        test_forward_priority();
        test_r15();
        test_load_use();
        test_flush_stall();
        test_unused_port();
        test_invalid_id();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
